// File: rtl/addr_sreg_if.sv
// addr_sreg_if: host-side serial/count bus of the address shift register
//   sin        serial data in, MSB first
//   shift_en_n active-low shift enable
//   count_n    active-low count enable (ignored while shifting)
//   dir        count direction, 0 = up, 1 = down
//   out        current register value
//   sout       serial readback, MSB of out
//   loaded     last completed burst was exactly DWIDTH bits
//   overrun    current/last burst exceeded DWIDTH bits
//   wrap       one-cycle pulse after a carry/borrow count
//   debug      low byte of out
interface addr_sreg_if #(
    parameter int DWIDTH = 24
) ();
    logic              sin;
    logic              shift_en_n;
    logic              count_n;
    logic              dir;
    logic [DWIDTH-1:0] out;
    logic              sout;
    logic              loaded;
    logic              overrun;
    logic              wrap;
    logic [7:0]        debug;

    modport master (
        output sin, shift_en_n, count_n, dir,
        input  out, sout, loaded, overrun, wrap, debug
    );

    modport slave (
        input  sin, shift_en_n, count_n, dir,
        output out, sout, loaded, overrun, wrap, debug
    );
endinterface

// File: rtl/addr_sreg.sv
// addr_sreg: serial-load address register with up/down step counting,
// serial readback, burst length checking and wrap detection.
//   clk      system clock, all state changes on the rising edge
//   reset_n  asynchronous active-low reset
//   bus      addr_sreg_if slave port (serial in, enables, value and status out)
module addr_sreg #(
    parameter int                DWIDTH    = 24,
    parameter logic [DWIDTH-1:0] STEP      = DWIDTH'(1),
    parameter logic [DWIDTH-1:0] RESET_VAL = '0
) (
    input logic       clk,
    input logic       reset_n,
    addr_sreg_if.slave bus
);
    localparam int             CW   = $clog2(DWIDTH + 1);
    localparam logic [CW-1:0]  FULL = CW'(DWIDTH);

    logic [DWIDTH-1:0] val;
    logic [CW-1:0]     bitcnt;
    logic              shift_en_d;
    logic              loaded_q;
    logic              overrun_q;
    logic              wrap_q;
    logic [DWIDTH:0]   sum;

    // One extra bit so the MSB carries the carry (up) or borrow (down).
    always_comb
        sum = bus.dir ? {1'b0, val} - {1'b0, STEP} : {1'b0, val} + {1'b0, STEP};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            val        <= RESET_VAL;
            bitcnt     <= '0;
            shift_en_d <= 1'b1;
            loaded_q   <= 1'b0;
            overrun_q  <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            shift_en_d <= bus.shift_en_n;
            if (!bus.shift_en_n) begin
                val    <= {val[DWIDTH-2:0], bus.sin};
                wrap_q <= 1'b0;
                if (shift_en_d) begin
                    bitcnt    <= CW'(1);
                    loaded_q  <= 1'b0;
                    overrun_q <= 1'b0;
                end else if (bitcnt < FULL) begin
                    bitcnt <= bitcnt + CW'(1);
                end else begin
                    overrun_q <= 1'b1;
                end
            end else begin
                // Burst end: judge the length, a count in this cycle still applies.
                if (!shift_en_d) begin
                    loaded_q <= (bitcnt == FULL) && !overrun_q;
                    bitcnt   <= '0;
                end
                wrap_q <= !bus.count_n && sum[DWIDTH];
                if (!bus.count_n)
                    val <= sum[DWIDTH-1:0];
            end
        end
    end

    assign bus.out     = val;
    assign bus.sout    = val[DWIDTH-1];
    assign bus.debug   = 8'(val);
    assign bus.loaded  = loaded_q;
    assign bus.overrun = overrun_q;
    assign bus.wrap    = wrap_q;
endmodule
